axi_lite_ram_slave: RTL and testbench
=====================================

AXI_LITE_RAM_SLAVE -- requirements
Module: axi_lite_ram_slave

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL set the number of 64-bit RAM words (power of two, 2..65536).
REQ-002 Parameter BASE_ADDR, default 32'h8000_0000, SHALL set the byte address of word 0.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 araddr  in  32  read byte address; arvalid  in  1; arready  out  1.
REQ-006 rdata  out  64  read data; rresp  out  2  (00 OKAY, 10 SLVERR); rvalid  out  1; rready  in  1.
REQ-007 awaddr  in  32  write byte address; awvalid  in  1; awready  out  1.
REQ-008 wdata  in  64; wstrb  in  8  byte enables (bit i = wdata[8i+7:8i]); wvalid  in  1; wready  out  1.
REQ-009 bresp  out  2  write response; bvalid  out  1; bready  in  1.

Function
REQ-010 Handshake on any channel SHALL complete on a rising edge where VALID and READY are both 1; VALID/payload outputs SHALL stay stable until their handshake.
REQ-011 Address decode: in range iff BASE_ADDR <= addr < BASE_ADDR+8*DEPTH; word index = (addr-BASE_ADDR)>>3; addr[2:0] ignored, no error.
REQ-012 Read FSM states R_IDLE, R_RESP; arready = 1 only in R_IDLE and not in reset.
REQ-013 R_IDLE -> R_RESP on AR handshake; at that edge rdata SHALL load mem[index] (in range, rresp=00) or 64'h0 (out of range, rresp=10) and rvalid SHALL go 1.
REQ-014 R_RESP -> R_IDLE on R handshake; rvalid SHALL drop the next cycle; read latency AR handshake to rvalid = 1 cycle; max throughput one read per 2 cycles.
REQ-015 Write FSM states W_IDLE, W_GOT_AW, W_GOT_W, W_RESP; awready = 1 in W_IDLE and W_GOT_W; wready = 1 in W_IDLE and W_GOT_AW.
REQ-016 W_IDLE: AW and W handshakes same edge -> commit, W_RESP; AW only -> latch awaddr, W_GOT_AW; W only -> latch wdata/wstrb, W_GOT_W.
REQ-017 W_GOT_AW on W handshake, or W_GOT_W on AW handshake -> commit, W_RESP.
REQ-018 Commit SHALL write only bytes with wstrb=1 of the addressed word at the commit edge; bvalid=1, bresp=00 from the next cycle; out-of-range write SHALL not modify memory and SHALL give bresp=10.
REQ-019 W_RESP -> W_IDLE on B handshake; bvalid SHALL drop the next cycle.
REQ-020 wstrb=8'h00 in range SHALL leave memory unchanged and return bresp=00.
REQ-021 Read and write FSMs SHALL run independently; AR handshake on the same edge as a write commit to the same word SHALL return the pre-write data.
REQ-022 A read whose AR handshake is at least one edge after a write commit SHALL return the new data.
REQ-023 Back-pressure (rready or bready held 0) SHALL hold rvalid/rdata/rresp or bvalid/bresp indefinitely with no lost or duplicated response.

Reset
REQ-024 While rst=1: arready, awready, wready, rvalid, bvalid = 0; rdata = 64'h0; rresp, bresp = 2'b00; both FSMs forced to IDLE.
REQ-025 Reset mid-transaction SHALL discard latched addresses/data and pending responses; a write not yet committed SHALL not reach memory.
REQ-026 Memory contents SHALL not be cleared by reset; arready, awready, wready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-027 Write 0x8000_0008 data 64'h1122334455667788 wstrb 8'hFF, then read 0x8000_0008 -> bresp 00, rdata 64'h1122334455667788, rvalid 1 cycle after AR handshake.
REQ-028 W handshake 3 cycles before AW, wstrb 8'h0F data 64'hFFFF_FFFF_AAAA_BBBB onto above word -> single bvalid after AW; readback 64'h11223344AAAABBBB.
REQ-029 Read 0x7FFF_FFF8 and write 0x8000_2000 (DEPTH 1024) -> rresp 10 rdata 0; bresp 10; readback of word 0 unchanged.
REQ-030 rready held 0 for 5 cycles after rvalid -> rvalid/rdata stable, arready 0 throughout; one response after rready=1.
REQ-031 Same-edge AR handshake and write commit to 0x8000_0010 (old 64'hA, new 64'hB) -> rdata 64'hA; next read returns 64'hB.
REQ-032 rst pulsed 1 cycle while in W_GOT_AW and while rvalid=1 -> rvalid/bvalid 0, ready outputs 1 after reset, target word unchanged.

Source files
------------

// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite slave backed by a DEPTH x 64-bit RAM mapped at BASE_ADDR.
// The read and write channels run as two independent FSMs; addresses
// outside the window return SLVERR and never touch memory.
module axi_lite_ram_slave #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // read address channel
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  // read data channel
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  // write address channel
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  // write data channel
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  // write response channel
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Size of the window in bytes, one bit wider so 8*DEPTH never overflows.
  localparam logic [32:0] SPAN = 33'(DEPTH) << 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_GOT_AW,
    W_GOT_W,
    W_RESP
  } w_state_t;

  // Storage: deliberately has no reset so contents survive rst.
  logic [63:0] mem [DEPTH];

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [63:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [1:0]  bresp_q;

  // Half of a split write transaction, held until its partner arrives.
  logic [31:0] aw_addr_q;
  logic [63:0] w_data_q;
  logic [7:0]  w_strb_q;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  // Merged view of the write that commits on this edge.
  logic        commit;
  logic [31:0] c_addr;
  logic [63:0] c_data;
  logic [7:0]  c_strb;

  logic [31:0]      rd_off, wr_off;
  logic             rd_hit, wr_hit;
  logic [IDX_W-1:0] rd_idx, wr_idx;

  // Ready/valid are derived from state and forced low while rst is held.
  assign arready = (r_state == R_IDLE) && !rst;
  assign rvalid  = (r_state == R_RESP) && !rst;
  assign awready = ((w_state == W_IDLE) || (w_state == W_GOT_W)) && !rst;
  assign wready  = ((w_state == W_IDLE) || (w_state == W_GOT_AW)) && !rst;
  assign bvalid  = (w_state == W_RESP) && !rst;

  assign rdata = rst ? 64'h0 : rdata_q;
  assign rresp = rst ? 2'b00 : rresp_q;
  assign bresp = rst ? 2'b00 : bresp_q;

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid  && rready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;
  assign b_hs  = bvalid  && bready;

  // Decode the read address into a hit flag and a word index; addr[2:0] is ignored.
  always_comb begin
    rd_off = araddr - BASE_ADDR;
    rd_hit = (araddr >= BASE_ADDR) && ({1'b0, rd_off} < SPAN);
    rd_idx = rd_off[IDX_W+2:3];
  end

  // Same decode for the address of the committing write.
  always_comb begin
    wr_off = c_addr - BASE_ADDR;
    wr_hit = (c_addr >= BASE_ADDR) && ({1'b0, wr_off} < SPAN);
    wr_idx = wr_off[IDX_W+2:3];
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // Read FSM next state: one outstanding read at a time.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_RESP;
      R_RESP:  if (r_hs)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Capture read data and response at the AR handshake; held until the R handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 64'h0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_hit ? mem[rd_idx] : 64'h0;
      rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // Write FSM next state and commit selection from live inputs or latched halves.
  always_comb begin
    w_next = w_state;
    commit = 1'b0;
    c_addr = awaddr;
    c_data = wdata;
    c_strb = wstrb;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          w_next = W_RESP;
        end else if (aw_hs) begin
          w_next = W_GOT_AW;
        end else if (w_hs) begin
          w_next = W_GOT_W;
        end
      end
      W_GOT_AW: begin
        c_addr = aw_addr_q;
        if (w_hs) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_GOT_W: begin
        c_data = w_data_q;
        c_strb = w_strb_q;
        if (aw_hs) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Hold whichever write half arrived first; reset discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_addr_q <= 32'h0;
      w_data_q  <= 64'h0;
      w_strb_q  <= 8'h0;
    end else begin
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

  // Write response is decided at commit and held until the B handshake.
  always_ff @(posedge clk) begin
    if (rst)         bresp_q <= RESP_OKAY;
    else if (commit) bresp_q <= wr_hit ? RESP_OKAY : RESP_SLVERR;
  end

  // Byte-enabled memory update; a same-edge read still sees the old word.
  always_ff @(posedge clk) begin
    if (commit && wr_hit) begin
      for (int i = 0; i < 8; i++) begin
        if (c_strb[i]) mem[wr_idx][8*i +: 8] <= c_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Directed self-checking bench for axi_lite_ram_slave (default parameters).
// Inputs change on the falling edge and outputs are checked there too.
module tb_axi_lite_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int tests_run    = 0;
  int tests_failed = 0;

  axi_lite_ram_slave dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case some wait loop never ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Let the current input values act for the given number of clock cycles.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Complete write with AW and W together, then collect the B response.
  task automatic axiWrite(input string tag, input logic [31:0] addr,
                          input logic [63:0] data, input logic [7:0] strb,
                          input logic [1:0] exp_resp);
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    applyStimulus(1);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int n = 0; n < 8 && !bvalid; n++) applyStimulus(1);
    checkOutput({tag, " bvalid"}, bvalid, 1'b1);
    checkOutput({tag, " bresp"}, bresp, exp_resp);
    bready = 1'b1;
    applyStimulus(1);
    bready = 1'b0;
    checkOutput({tag, " bvalid drop"}, bvalid, 1'b0);
  endtask

  // Complete read; rvalid must be up one cycle after the AR handshake.
  task automatic axiRead(input string tag, input logic [31:0] addr,
                         input logic [63:0] exp_data, input logic [1:0] exp_resp);
    araddr = addr; arvalid = 1'b1;
    applyStimulus(1);
    arvalid = 1'b0;
    checkOutput({tag, " rvalid latency"}, rvalid, 1'b1);
    for (int n = 0; n < 8 && !rvalid; n++) applyStimulus(1);
    checkOutput({tag, " rdata"}, rdata, exp_data);
    checkOutput({tag, " rresp"}, rresp, exp_resp);
    rready = 1'b1;
    applyStimulus(1);
    rready = 1'b0;
    checkOutput({tag, " rvalid drop"}, rvalid, 1'b0);
  endtask

  // Directed sequence, one step after another.
  initial begin
    rst = 1'b1;
    araddr = 32'h0; arvalid = 1'b0; rready = 1'b0;
    awaddr = 32'h0; awvalid = 1'b0;
    wdata = 64'h0; wstrb = 8'h0; wvalid = 1'b0; bready = 1'b0;

    // Reset state.
    applyStimulus(2);
    checkOutput("rst arready", arready, 1'b0);
    checkOutput("rst awready", awready, 1'b0);
    checkOutput("rst wready", wready, 1'b0);
    checkOutput("rst rvalid", rvalid, 1'b0);
    checkOutput("rst bvalid", bvalid, 1'b0);
    checkOutput("rst rdata", rdata, 64'h0);
    checkOutput("rst rresp", rresp, 2'b00);
    checkOutput("rst bresp", bresp, 2'b00);
    rst = 1'b0;
    #1;
    checkOutput("post-rst arready", arready, 1'b1);
    checkOutput("post-rst awready", awready, 1'b1);
    checkOutput("post-rst wready", wready, 1'b1);

    // Basic write then read back.
    axiWrite("wr08", 32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 2'b00);
    axiRead("rd08", 32'h8000_0008, 64'h1122_3344_5566_7788, 2'b00);

    // W arrives three cycles ahead of AW, low four bytes only.
    wdata = 64'hFFFF_FFFF_AAAA_BBBB; wstrb = 8'h0F; wvalid = 1'b1;
    applyStimulus(1);
    wvalid = 1'b0;
    checkOutput("got_w wready", wready, 1'b0);
    checkOutput("got_w awready", awready, 1'b1);
    checkOutput("got_w bvalid", bvalid, 1'b0);
    applyStimulus(2);
    checkOutput("got_w wait bvalid", bvalid, 1'b0);
    awaddr = 32'h8000_0008; awvalid = 1'b1;
    applyStimulus(1);
    awvalid = 1'b0;
    checkOutput("late aw bvalid", bvalid, 1'b1);
    checkOutput("late aw bresp", bresp, 2'b00);
    bready = 1'b1;
    applyStimulus(1);
    bready = 1'b0;
    checkOutput("late aw single b", bvalid, 1'b0);
    applyStimulus(1);
    checkOutput("late aw no repeat b", bvalid, 1'b0);
    axiRead("rd08 merged", 32'h8000_0008, 64'h1122_3344_AAAA_BBBB, 2'b00);

    // Out-of-range accesses; the write wraps onto word 0 if decode is wrong.
    axiWrite("wr00", 32'h8000_0000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 2'b00);
    axiRead("rd below", 32'h7FFF_FFF8, 64'h0, 2'b10);
    axiWrite("wr above", 32'h8000_2000, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b10);
    axiRead("rd00", 32'h8000_0000, 64'hDEAD_BEEF_CAFE_F00D, 2'b00);
    axiRead("rd00 unaligned", 32'h8000_0005, 64'hDEAD_BEEF_CAFE_F00D, 2'b00);

    // Zero strobes: OKAY and no change.
    axiWrite("wr nostrb", 32'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 2'b00);
    axiRead("rd nostrb", 32'h8000_0008, 64'h1122_3344_AAAA_BBBB, 2'b00);

    // R back-pressure for five cycles while a second AR waits.
    araddr = 32'h8000_0008; arvalid = 1'b1;
    applyStimulus(1);
    araddr = 32'h8000_0000;
    checkOutput("bp rvalid", rvalid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("bp%0d rvalid", i), rvalid, 1'b1);
      checkOutput($sformatf("bp%0d rdata", i), rdata, 64'h1122_3344_AAAA_BBBB);
      checkOutput($sformatf("bp%0d arready", i), arready, 1'b0);
    end
    arvalid = 1'b0;
    rready = 1'b1;
    applyStimulus(1);
    rready = 1'b0;
    checkOutput("bp rvalid drop", rvalid, 1'b0);
    checkOutput("bp arready back", arready, 1'b1);

    // B back-pressure on a write to word 3.
    awaddr = 32'h8000_0018; awvalid = 1'b1;
    wdata = 64'h0C0C_0C0C_0C0C_0C0C; wstrb = 8'hFF; wvalid = 1'b1;
    applyStimulus(1);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("bbp%0d bvalid", i), bvalid, 1'b1);
      checkOutput($sformatf("bbp%0d awready", i), awready, 1'b0);
    end
    checkOutput("bbp bresp", bresp, 2'b00);
    bready = 1'b1;
    applyStimulus(1);
    bready = 1'b0;
    checkOutput("bbp bvalid drop", bvalid, 1'b0);

    // Read and write commit to the same word on the same edge.
    axiWrite("wr10 old", 32'h8000_0010, 64'hA, 8'hFF, 2'b00);
    araddr = 32'h8000_0010; arvalid = 1'b1;
    awaddr = 32'h8000_0010; awvalid = 1'b1;
    wdata = 64'hB; wstrb = 8'hFF; wvalid = 1'b1;
    applyStimulus(1);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("same-edge rvalid", rvalid, 1'b1);
    checkOutput("same-edge rdata", rdata, 64'hA);
    checkOutput("same-edge bvalid", bvalid, 1'b1);
    rready = 1'b1; bready = 1'b1;
    applyStimulus(1);
    rready = 1'b0; bready = 1'b0;
    checkOutput("same-edge rvalid drop", rvalid, 1'b0);
    checkOutput("same-edge bvalid drop", bvalid, 1'b0);
    axiRead("rd10 new", 32'h8000_0010, 64'hB, 2'b00);

    // Reset with AW latched and a read response pending.
    awaddr = 32'h8000_0018; awvalid = 1'b1;
    araddr = 32'h8000_0018; arvalid = 1'b1;
    applyStimulus(1);
    awvalid = 1'b0; arvalid = 1'b0;
    checkOutput("got_aw awready", awready, 1'b0);
    checkOutput("got_aw wready", wready, 1'b1);
    checkOutput("pending rvalid", rvalid, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("mid-rst rvalid", rvalid, 1'b0);
    checkOutput("mid-rst wready", wready, 1'b0);
    checkOutput("mid-rst rdata", rdata, 64'h0);
    applyStimulus(1);
    rst = 1'b0;
    #1;
    checkOutput("after rst rvalid", rvalid, 1'b0);
    checkOutput("after rst bvalid", bvalid, 1'b0);
    checkOutput("after rst arready", arready, 1'b1);
    checkOutput("after rst awready", awready, 1'b1);
    checkOutput("after rst wready", wready, 1'b1);
    wdata = 64'h5555_6666_7777_8888; wstrb = 8'hFF; wvalid = 1'b1;
    applyStimulus(1);
    wvalid = 1'b0;
    checkOutput("discarded aw bvalid", bvalid, 1'b0);
    checkOutput("discarded aw wready", wready, 1'b0);
    awaddr = 32'h8000_0020; awvalid = 1'b1;
    applyStimulus(1);
    awvalid = 1'b0;
    checkOutput("rst-recover bvalid", bvalid, 1'b1);
    checkOutput("rst-recover bresp", bresp, 2'b00);
    bready = 1'b1;
    applyStimulus(1);
    bready = 1'b0;
    axiRead("rd18 kept", 32'h8000_0018, 64'h0C0C_0C0C_0C0C_0C0C, 2'b00);
    axiRead("rd20 new", 32'h8000_0020, 64'h5555_6666_7777_8888, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
